vga_box_painter: RTL and testbench



---
 rtl/vga_box_painter_if.sv | 35 +++
 rtl/vga_box_painter.sv | 202 ++++++++++++++++++++
 tb/tb_vga_box_painter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_box_painter_if.sv
// Bus between the VGA timing block and the box painter.
// Streaming, one pixel per clock: there is no valid/ready pair. Every cycle
// carries one pixel position; the painter has no backpressure and always consumes it.
// The dbg_* signals expose the bounce FSM state, position and direction so that checkers can observe them.
interface vga_box_painter_if;
    logic [10:0] count_h;
    logic [10:0] count_v;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        pause;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        h_sync;
    logic        v_sync;
    logic [7:0]  bounce_count;
    logic [10:0] dbg_x;
    logic [10:0] dbg_y;
    logic        dbg_dir_x;   // 0 = RIGHT, 1 = LEFT
    logic        dbg_dir_y;   // 0 = DOWN,  1 = UP

    // Timing side: drives counts/syncs/pause, receives pixels.
    modport master (
        output count_h, count_v, h_sync_in, v_sync_in, pause,
        input  r, g, b, h_sync, v_sync, bounce_count,
        input  dbg_x, dbg_y, dbg_dir_x, dbg_dir_y
    );

    // Painter side.
    modport slave (
        input  count_h, count_v, h_sync_in, v_sync_in, pause,
        output r, g, b, h_sync, v_sync, bounce_count,
        output dbg_x, dbg_y, dbg_dir_x, dbg_dir_y
    );
endinterface

// File: rtl/vga_box_painter.sv
// vga_box_painter: draws a bouncing solid square over a blue background.
// The box position updates once per frame on the frame tick (count_h==0 and count_v==0).
// RGB and syncs are registered together, so they share a latency of 1 cycle.
// Optional macro VGA_BOX_COLOR_CYCLE_EN: the box colour steps red->green->yellow->white on each bounce event.
module vga_box_painter #(
    parameter int H_START  = 241,
    parameter int H_ACTIVE = 799,
    parameter int V_START  = 67,
    parameter int V_ACTIVE = 599,
    parameter int BOX      = 32,
    parameter int STEP     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_box_painter_if.slave  bus
);

    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_x_t;
    typedef enum logic {DIR_DOWN  = 1'b0, DIR_UP   = 1'b1} dir_y_t;

    localparam logic [11:0] L_H_START = 12'(H_START);
    localparam logic [11:0] L_H_END   = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] L_V_START = 12'(V_START);
    localparam logic [11:0] L_V_END   = 12'(V_START + V_ACTIVE);
    localparam logic [11:0] L_BOX     = 12'(BOX);
    localparam logic [11:0] L_STEP    = 12'(STEP);
    localparam logic [11:0] L_X_MAX   = 12'(H_ACTIVE - BOX);
    localparam logic [11:0] L_Y_MAX   = 12'(V_ACTIVE - BOX);

    logic [10:0] r_x, r_y;
    dir_x_t      r_dir_x;
    dir_y_t      r_dir_y;
    logic [7:0]  r_bounce_count;
    logic [3:0]  r_r, r_g, r_b;
    logic        r_h_sync, r_v_sync;

    logic [10:0] w_next_x, w_next_y;
    dir_x_t      w_next_dir_x;
    dir_y_t      w_next_dir_y;
    logic        w_bounce_x, w_bounce_y, w_bounce;
    logic        w_tick, w_update;
    logic [10:0] w_px, w_py;
    logic        w_active, w_in_box;
    logic [11:0] w_box_rgb;

    assign w_tick   = (bus.count_h == 11'd0) && (bus.count_v == 11'd0);
    assign w_update = w_tick && !bus.pause;
    assign w_bounce = w_bounce_x || w_bounce_y;

    // X axis FSM: next position/direction and bounce flag for this tick.
    always_comb begin
        w_next_x     = r_x;
        w_next_dir_x = r_dir_x;
        w_bounce_x   = 1'b0;
        if (w_update) begin
            case (r_dir_x)
                DIR_RIGHT: begin
                    if (({1'b0, r_x} + L_STEP) >= L_X_MAX) begin
                        w_next_x     = L_X_MAX[10:0];
                        w_next_dir_x = DIR_LEFT;
                        w_bounce_x   = 1'b1;
                    end else begin
                        w_next_x = r_x + L_STEP[10:0];
                    end
                end
                default: begin
                    if ({1'b0, r_x} <= L_STEP) begin
                        w_next_x     = 11'd0;
                        w_next_dir_x = DIR_RIGHT;
                        w_bounce_x   = 1'b1;
                    end else begin
                        w_next_x = r_x - L_STEP[10:0];
                    end
                end
            endcase
        end
    end

    // Y axis FSM: same rules as X against the vertical limit.
    always_comb begin
        w_next_y     = r_y;
        w_next_dir_y = r_dir_y;
        w_bounce_y   = 1'b0;
        if (w_update) begin
            case (r_dir_y)
                DIR_DOWN: begin
                    if (({1'b0, r_y} + L_STEP) >= L_Y_MAX) begin
                        w_next_y     = L_Y_MAX[10:0];
                        w_next_dir_y = DIR_UP;
                        w_bounce_y   = 1'b1;
                    end else begin
                        w_next_y = r_y + L_STEP[10:0];
                    end
                end
                default: begin
                    if ({1'b0, r_y} <= L_STEP) begin
                        w_next_y     = 11'd0;
                        w_next_dir_y = DIR_DOWN;
                        w_bounce_y   = 1'b1;
                    end else begin
                        w_next_y = r_y - L_STEP[10:0];
                    end
                end
            endcase
        end
    end

    // Position/direction state; a corner hit increments the bounce count once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x            <= 11'd0;
            r_y            <= 11'd0;
            r_dir_x        <= DIR_RIGHT;
            r_dir_y        <= DIR_DOWN;
            r_bounce_count <= 8'd0;
        end else begin
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_dir_x <= w_next_dir_x;
            r_dir_y <= w_next_dir_y;
            if (w_bounce) begin
                r_bounce_count <= r_bounce_count + 8'd1;
            end
        end
    end

`ifdef VGA_BOX_COLOR_CYCLE_EN
    logic [1:0] r_color_idx;

    // Colour index steps once per bounce event and wraps from 3 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color_idx <= 2'd0;
        end else if (w_bounce) begin
            r_color_idx <= r_color_idx + 2'd1;
        end
    end

    // Box colour lookup by index.
    always_comb begin
        w_box_rgb = 12'hF00;
        case (r_color_idx)
            2'd0:    w_box_rgb = 12'hF00;
            2'd1:    w_box_rgb = 12'h0F0;
            2'd2:    w_box_rgb = 12'hFF0;
            default: w_box_rgb = 12'hFFF;
        endcase
    end
`else
    assign w_box_rgb = 12'hF00;
`endif

    // Pixel coordinates wrap outside the active area, so they are only trusted when w_active is set.
    assign w_px = bus.count_h - L_H_START[10:0];
    assign w_py = bus.count_v - L_V_START[10:0];

    assign w_active = ({1'b0, bus.count_h} >= L_H_START) && ({1'b0, bus.count_h} < L_H_END) &&
                      ({1'b0, bus.count_v} >= L_V_START) && ({1'b0, bus.count_v} < L_V_END);

    assign w_in_box = w_active &&
                      ({1'b0, w_px} >= {1'b0, r_x}) && ({1'b0, w_px} < ({1'b0, r_x} + L_BOX)) &&
                      ({1'b0, w_py} >= {1'b0, r_y}) && ({1'b0, w_py} < ({1'b0, r_y} + L_BOX));

    // Pixel and sync output registers keep RGB aligned with the delayed syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r      <= 4'd0;
            r_g      <= 4'd0;
            r_b      <= 4'd0;
            r_h_sync <= 1'b0;
            r_v_sync <= 1'b0;
        end else begin
            r_h_sync <= bus.h_sync_in;
            r_v_sync <= bus.v_sync_in;
            if (w_in_box) begin
                r_r <= w_box_rgb[11:8];
                r_g <= w_box_rgb[7:4];
                r_b <= w_box_rgb[3:0];
            end else if (w_active) begin
                r_r <= 4'h0;
                r_g <= 4'h0;
                r_b <= 4'h4;
            end else begin
                r_r <= 4'h0;
                r_g <= 4'h0;
                r_b <= 4'h0;
            end
        end
    end

    assign bus.r            = r_r;
    assign bus.g            = r_g;
    assign bus.b            = r_b;
    assign bus.h_sync       = r_h_sync;
    assign bus.v_sync       = r_v_sync;
    assign bus.bounce_count = r_bounce_count;
    assign bus.dbg_x        = r_x;
    assign bus.dbg_y        = r_y;
    assign bus.dbg_dir_x    = r_dir_x;
    assign bus.dbg_dir_y    = r_dir_y;

endmodule

// File: tb/tb_vga_box_painter.sv
// Bench for vga_box_painter: a default-size instance plus a small 100x100 instance for the corner case.
// The reference model keeps the box as position plus signed velocity and clamps at the edges.
`timescale 1ns/1ps
module tb_vga_box_painter;

    localparam int HS = 241, HA = 799, VS = 67, VA = 599, BX = 32, ST = 2;
    localparam int XM = HA - BX;   // 767
    localparam int YM = VA - BX;   // 567

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // reference model state for instance A
    int m_x, m_y, m_vx, m_vy, m_bc, m_ci;

    vga_box_painter_if ifa ();
    vga_box_painter_if ifb ();

    vga_box_painter u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    vga_box_painter #(.H_ACTIVE(100), .V_ACTIVE(100)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // model
    task automatic model_reset();
        m_x = 0; m_y = 0; m_vx = ST; m_vy = ST; m_bc = 0; m_ci = 0;
    endtask

    task automatic move_axis(inout int pos, inout int vel, input int lim, output bit bounced);
        int np;
        np = pos + vel;
        bounced = 1'b0;
        if (np >= lim) begin
            np = lim; vel = -ST; bounced = 1'b1;
        end else if (np <= 0) begin
            np = 0; vel = ST; bounced = 1'b1;
        end
        pos = np;
    endtask

    task automatic model_tick(input bit p);
        bit bx, by;
        if (!p) begin
            move_axis(m_x, m_vx, XM, bx);
            move_axis(m_y, m_vy, YM, by);
            if (bx || by) begin
                m_bc = (m_bc + 1) % 256;
                m_ci = (m_ci + 1) % 4;
            end
        end
    endtask

    function automatic logic [11:0] box_colour(input int ci);
`ifdef VGA_BOX_COLOR_CYCLE_EN
        case (ci)
            0: return 12'hF00;
            1: return 12'h0F0;
            2: return 12'hFF0;
            default: return 12'hFFF;
        endcase
`else
        return (ci >= 0) ? 12'hF00 : 12'hF00;
`endif
    endfunction

    function automatic logic [11:0] exp_rgb(input int h, input int v);
        int px, py;
        if (h < HS || h >= HS + HA || v < VS || v >= VS + VA) return 12'h000;
        px = h - HS;
        py = v - VS;
        if (px >= m_x && px < m_x + BX && py >= m_y && py < m_y + BX) return box_colour(m_ci);
        return 12'h004;
    endfunction

    // driver tasks
    task automatic check_state_a(input string tag);
        check({tag, "_x"},  32'(ifa.dbg_x), 32'(m_x));
        check({tag, "_y"},  32'(ifa.dbg_y), 32'(m_y));
        check({tag, "_dx"}, 32'(ifa.dbg_dir_x), 32'(m_vx < 0));
        check({tag, "_dy"}, 32'(ifa.dbg_dir_y), 32'(m_vy < 0));
        check({tag, "_bc"}, 32'(ifa.bounce_count), 32'(m_bc));
    endtask

    task automatic pixel_a(input string tag, input int h, input int v, input bit hs, input bit vs);
        ifa.count_h = 11'(h);
        ifa.count_v = 11'(v);
        ifa.h_sync_in = hs;
        ifa.v_sync_in = vs;
        tick_clk();
        check({tag, "_rgb"}, 32'({ifa.r, ifa.g, ifa.b}), 32'(exp_rgb(h, v)));
        check({tag, "_hs"}, 32'(ifa.h_sync), 32'(hs));
        check({tag, "_vs"}, 32'(ifa.v_sync), 32'(vs));
    endtask

    task automatic frame_tick_a(input bit p);
        ifa.count_h = 11'd0;
        ifa.count_v = 11'd0;
        ifa.pause = p;
        tick_clk();
        model_tick(p);
        check("tick_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        ifa.count_h = 11'd100;
        ifa.count_v = 11'd10;
        ifa.pause = 1'b0;
        tick_clk();
        check_state_a("tick");
    endtask

    task automatic frame_tick_b();
        ifb.count_h = 11'd0;
        ifb.count_v = 11'd0;
        tick_clk();
        ifb.count_h = 11'd100;
        ifb.count_v = 11'd10;
        tick_clk();
    endtask

    initial begin
        int h, v;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0;
        ifa.count_h = 11'd100; ifa.count_v = 11'd10;
        ifa.h_sync_in = 1'b1; ifa.v_sync_in = 1'b1; ifa.pause = 1'b0;
        ifb.count_h = 11'd100; ifb.count_v = 11'd10;
        ifb.h_sync_in = 1'b0; ifb.v_sync_in = 1'b0; ifb.pause = 1'b0;

        // reset state
        tick_clk();
        tick_clk();
        check("rst_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        check("rst_hs", 32'(ifa.h_sync), 32'h0);
        check("rst_vs", 32'(ifa.v_sync), 32'h0);
        check_state_a("rst");
        rst_n = 1'b1;

        // directed pixels with the box at (0,0)
        pixel_a("pix_corner", 241, 67, 1'b0, 1'b0);
        check("pix_corner_const", 32'({ifa.r, ifa.g, ifa.b}), 32'hF00);
        pixel_a("pix_right_edge", 273, 67, 1'b0, 1'b0);
        check("pix_right_edge_const", 32'({ifa.r, ifa.g, ifa.b}), 32'h004);
        pixel_a("pix_blank", 100, 67, 1'b0, 1'b0);
        check("pix_blank_const", 32'({ifa.r, ifa.g, ifa.b}), 32'h000);
        pixel_a("pix_last", 241 + 798, 67 + 598, 1'b1, 1'b0);
        pixel_a("pix_past", 241 + 799, 67 + 598, 1'b0, 1'b1);

        // first tick
        frame_tick_a(1'b0);
        check("tick1_x", 32'(ifa.dbg_x), 32'd2);
        check("tick1_y", 32'(ifa.dbg_y), 32'd2);
        check("tick1_bc", 32'(ifa.bounce_count), 32'd0);
        pixel_a("pix_moved_out", 242, 68, 1'b0, 1'b0);
        pixel_a("pix_moved_in", 243, 69, 1'b0, 1'b0);

        // run to the right-edge bounce
        for (int i = 2; i <= 384; i++) begin
            frame_tick_a(1'b0);
            if (i == 284) begin
                check("y_bounce_y", 32'(ifa.dbg_y), 32'd567);
                check("y_bounce_dy", 32'(ifa.dbg_dir_y), 32'd1);
            end
            if (i == 383) check("x_before", 32'(ifa.dbg_x), 32'd766);
        end
        check("x_bounce_x", 32'(ifa.dbg_x), 32'd767);
        check("x_bounce_dx", 32'(ifa.dbg_dir_x), 32'd1);
        check("x_bounce_bc", 32'(ifa.bounce_count), 32'd2);

        // pause holds everything
        for (int i = 0; i < 10; i++) frame_tick_a(1'b1);
        check("pause_x", 32'(ifa.dbg_x), 32'd767);
        check("pause_bc", 32'(ifa.bounce_count), 32'd2);

        // sync follow
        pixel_a("sync10", 300, 300, 1'b1, 1'b0);
        pixel_a("sync01", 300, 300, 1'b0, 1'b1);
        pixel_a("sync11", 300, 300, 1'b1, 1'b1);

        // randomized mix of ticks (some paused) and pixels near and away from the box
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: frame_tick_a($urandom_range(0, 3) == 0);
                1: begin
                    h = HS + m_x + $urandom_range(0, BX + 3) - 2;
                    v = VS + m_y + $urandom_range(0, BX + 3) - 2;
                    pixel_a("rnd_near", h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                default: begin
                    h = $urandom_range(0, 1100);
                    v = $urandom_range(0, 700);
                    if (h == 0 && v == 0) h = 1;
                    pixel_a("rnd_any", h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            endcase
        end
        check_state_a("rnd_end");

        // corner hit on the small instance: both axes reach 68 on tick 34
        for (int i = 1; i <= 33; i++) frame_tick_b();
        check("corner_pre_x", 32'(ifb.dbg_x), 32'd66);
        check("corner_pre_bc", 32'(ifb.bounce_count), 32'd0);
        frame_tick_b();
        check("corner_x", 32'(ifb.dbg_x), 32'd68);
        check("corner_y", 32'(ifb.dbg_y), 32'd68);
        check("corner_dirs", 32'({ifb.dbg_dir_x, ifb.dbg_dir_y}), 32'h3);
        check("corner_bc", 32'(ifb.bounce_count), 32'd1);
        ifb.count_h = 11'(241 + 70);
        ifb.count_v = 11'(67 + 70);
        tick_clk();
`ifdef VGA_BOX_COLOR_CYCLE_EN
        check("corner_rgb", 32'({ifb.r, ifb.g, ifb.b}), 32'h0F0);
`else
        check("corner_rgb", 32'({ifb.r, ifb.g, ifb.b}), 32'hF00);
`endif
        ifb.count_h = 11'd100;
        ifb.count_v = 11'd10;

        // asynchronous reset mid-line
        ifa.count_h = 11'(HS + m_x + 1);
        ifa.count_v = 11'(VS + m_y + 1);
        ifa.h_sync_in = 1'b1;
        ifa.v_sync_in = 1'b1;
        tick_clk();
        check("pre_rst_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'(exp_rgb(HS + m_x + 1, VS + m_y + 1)));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_rgb", 32'({ifa.r, ifa.g, ifa.b}), 32'h0);
        check("midrst_hs", 32'(ifa.h_sync), 32'h0);
        check("midrst_vs", 32'(ifa.v_sync), 32'h0);
        check_state_a("midrst");
        check("midrst_b_bc", 32'(ifb.bounce_count), 32'h0);
        tick_clk();
        rst_n = 1'b1;
        pixel_a("post_rst_box", 241, 67, 1'b1, 1'b0);
        pixel_a("post_rst_bg", 500, 300, 1'b0, 1'b1);
        check_state_a("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
